// File: rtl/uart_dma.sv
// uart_dma: UART frame parser (rx) and DMA-to-UART byte FIFO with send FSM (tx).
// The rx and tx paths share only the clock and reset.
module uart_dma #(
  parameter int unsigned P_TX_FIFO_DEPTH = 256,   // power of two, >= 2
  parameter int unsigned P_RX_TIMEOUT    = 52_080
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_usr_tx_data,
  output logic       o_usr_tx_valid,
  input  logic       i_usr_tx_ready,
  input  logic [7:0] i_usr_rx_data,
  input  logic       i_usr_rx_valid,
  input  logic [7:0] i_uart_DMA_tdata,
  input  logic       i_uart_DMA_tlast,
  input  logic       i_uart_DMA_tvalid,
  output logic       o_uart_DMA_tready,
  output logic [7:0] o_uart_DMA_rlen,
  output logic [7:0] o_uart_DMA_rdata,
  output logic       o_uart_DMA_rlast,
  output logic       o_uart_DMA_rvalid
);

  localparam int unsigned AW = $clog2(P_TX_FIFO_DEPTH);
  localparam int unsigned CW = $clog2(P_TX_FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(P_RX_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(P_TX_FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(P_RX_TIMEOUT - 1);
  localparam logic [7:0]    PREAMBLE = 8'h55;

  typedef enum logic [1:0] {RX_HEAD, RX_CMD, RX_LEN, RX_DATA} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_READ, TX_SEND, TX_HOLD} tx_state_e;

  // ---------------------------------------------------------------- rx path
  rx_state_e       rx_state_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      cnt_q;
  logic [7:0]      rlen_q;
  logic [7:0]      rdata_q;
  logic            rlast_q;
  logic            rvalid_q;

  // Frame parser: preamble, command (consumed, not used downstream), length, payload.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state_q <= RX_HEAD;
      tmo_q      <= '0;
      cnt_q      <= '0;
      rlen_q     <= '0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      if (rx_state_q == RX_HEAD) begin
        tmo_q <= '0;
        if (i_usr_rx_valid && (i_usr_rx_data == PREAMBLE)) begin
          rx_state_q <= RX_CMD;
        end
      end else if (i_usr_rx_valid) begin
        tmo_q <= '0;
        case (rx_state_q)
          RX_CMD: rx_state_q <= RX_LEN;
          RX_LEN: begin
            rlen_q     <= i_usr_rx_data;
            cnt_q      <= '0;
            rx_state_q <= (i_usr_rx_data == 8'd0) ? RX_HEAD : RX_DATA;
          end
          RX_DATA: begin
            rdata_q  <= i_usr_rx_data;
            rvalid_q <= 1'b1;
            if (8'(cnt_q + 8'd1) == rlen_q) begin
              rlast_q    <= 1'b1;
              rx_state_q <= RX_HEAD;
            end else begin
              cnt_q <= 8'(cnt_q + 8'd1);
            end
          end
          default: rx_state_q <= RX_HEAD;
        endcase
      end else if (tmo_q == TMO_LAST) begin
        // Inter-byte silence expired: abandon the partial frame quietly.
        tmo_q      <= '0;
        rx_state_q <= RX_HEAD;
      end else begin
        tmo_q <= TW'(tmo_q + TW'(1));
      end
    end
  end

  assign o_uart_DMA_rlen   = rlen_q;
  assign o_uart_DMA_rdata  = rdata_q;
  assign o_uart_DMA_rlast  = rlast_q;
  assign o_uart_DMA_rvalid = rvalid_q;

  // ---------------------------------------------------------------- tx path
  logic [7:0]    mem [P_TX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          tready_q;
  logic          wr_en_c;
  logic          rd_en_c;
  tx_state_e     tx_state_q;
  logic [1:0]    hold_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;

  // Burst boundaries do not affect transmission order.
  logic unused_tlast;
  assign unused_tlast = i_uart_DMA_tlast;

  assign wr_en_c = i_uart_DMA_tvalid && tready_q;
  assign rd_en_c = (tx_state_q == TX_READ);

  // Occupancy after this cycle's write/pop.
  always_comb begin
    count_d = count_q;
    if (wr_en_c && !rd_en_c) begin
      count_d = CW'(count_q + CW'(1));
    end else if (!wr_en_c && rd_en_c) begin
      count_d = CW'(count_q - CW'(1));
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge i_clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= i_uart_DMA_tdata;
    end
  end

  // FIFO pointers, occupancy and registered tready (low once full).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr_q <= AW'(wr_ptr_q + AW'(1));
      if (rd_en_c) rd_ptr_q <= AW'(rd_ptr_q + AW'(1));
      count_q  <= count_d;
      tready_q <= (count_d != DEPTH_C);
    end
  end

  assign o_uart_DMA_tready = tready_q;

  // Send FSM: pop one byte, pulse valid once, then wait out the UART.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_q <= TX_IDLE;
      hold_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if ((count_q != '0) && i_usr_tx_ready) begin
            tx_state_q <= TX_READ;
          end
        end
        TX_READ: begin
          tx_data_q  <= mem[rd_ptr_q];
          tx_valid_q <= 1'b1;
          tx_state_q <= TX_SEND;
        end
        TX_SEND: begin
          hold_q     <= '0;
          tx_state_q <= TX_HOLD;
        end
        TX_HOLD: begin
          // First two hold cycles ignore ready while the UART picks the byte up.
          if (hold_q != 2'd2) begin
            hold_q <= 2'(hold_q + 2'd1);
          end else if (i_usr_tx_ready) begin
            tx_state_q <= TX_IDLE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign o_usr_tx_data  = tx_data_q;
  assign o_usr_tx_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_dma.sv
// Self-checking bench for uart_dma: table-driven rx frames, tx scoreboard,
// timeout, overflow and reset-mid-operation sequences.
module tb_uart_dma;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       tready;
  logic [7:0] rlen;
  logic [7:0] rdata;
  logic       rlast;
  logic       rvalid;

  uart_dma #(.P_TX_FIFO_DEPTH(DEPTH), .P_RX_TIMEOUT(TMO)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .o_usr_tx_data     (tx_data),
    .o_usr_tx_valid    (tx_valid),
    .i_usr_tx_ready    (tx_ready),
    .i_usr_rx_data     (rx_data),
    .i_usr_rx_valid    (rx_valid),
    .i_uart_DMA_tdata  (tdata),
    .i_uart_DMA_tlast  (tlast),
    .i_uart_DMA_tvalid (tvalid),
    .o_uart_DMA_tready (tready),
    .o_uart_DMA_rlen   (rlen),
    .o_uart_DMA_rdata  (rdata),
    .o_uart_DMA_rlast  (rlast),
    .o_uart_DMA_rvalid (rvalid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------- scoreboards
  typedef struct {
    logic [7:0]  data;
    logic [7:0]  len;
    logic        last;
    int unsigned cyc;
  } rx_exp_t;

  typedef struct {
    logic [7:0] d;
    bit         ev;
    logic [7:0] el;
    bit         elast;
  } rx_vec_t;

  rx_exp_t    rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  rx_vec_t    vecs[$];

  // RX monitor: every rvalid pulse must match the next expected payload byte.
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (rx_exp_q.size() == 0) begin
        check("rx_unexpected_pulse", 32'(rdata), 32'hFFFF_FFFF);
      end else begin
        rx_exp_t e;
        e = rx_exp_q.pop_front();
        check("rx_data", 32'(rdata), 32'(e.data));
        check("rx_len",  32'(rlen),  32'(e.len));
        check("rx_last", 32'(rlast), 32'(e.last));
        check("rx_latency", cyc, e.cyc);
      end
    end
  end

  // UART transmitter model: busy for a few cycles after each byte.
  int          busy_cnt  = 0;
  bit          hold_busy = 1'b0;
  bit          tx_seen   = 1'b0;
  int unsigned tx_first_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else if (tx_valid) begin
      check("tx_valid_while_busy", 32'(tx_ready), 32'd1);
      if (tx_exp_q.size() == 0) begin
        check("tx_unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
      end else begin
        check("tx_data", 32'(tx_data), 32'(tx_exp_q.pop_front()));
      end
      if (!tx_seen) begin
        tx_seen      = 1'b1;
        tx_first_cyc = cyc;
      end
      busy_cnt = 5;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_ready = !hold_busy && (busy_cnt == 0);
  end

  // ---------------------------------------------------------- helpers
  task automatic add_vec(input logic [7:0] d, input bit ev, input logic [7:0] el, input bit elast);
    rx_vec_t v;
    v.d = d; v.ev = ev; v.el = el; v.elast = elast;
    vecs.push_back(v);
  endtask

  // Present one rx byte this cycle (caller has already synchronised to negedge).
  task automatic rx_put(input logic [7:0] d, input bit ev, input logic [7:0] el, input bit elast);
    if (ev) begin
      rx_exp_t e;
      e.data = d; e.len = el; e.last = elast; e.cyc = cyc + 1;
      rx_exp_q.push_back(e);
    end
    rx_data  = d;
    rx_valid = 1'b1;
  endtask

  task automatic rx_send(input logic [7:0] d, input bit ev, input logic [7:0] el, input bit elast);
    @(negedge clk);
    rx_put(d, ev, el, elast);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_drained(input int budget);
    for (int i = 0; i < budget && tx_exp_q.size() != 0; i++) @(negedge clk);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------- test
  initial begin
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
    tdata = '0; tlast = 1'b0; tvalid = 1'b0;

    // Rx vector table: byte, expect pulse, expected rlen, expected rlast.
    for (int r = 0; r < 5; r++) begin
      add_vec(8'h55, 0, 8'h00, 0); add_vec(8'h01, 0, 8'h00, 0);
      add_vec(8'h01, 0, 8'h00, 0); add_vec(8'h66, 1, 8'h01, 1);
    end
    add_vec(8'h55, 0, 8'h00, 0); add_vec(8'h02, 0, 8'h00, 0); add_vec(8'h03, 0, 8'h00, 0);
    add_vec(8'hA1, 1, 8'h03, 0); add_vec(8'hA2, 1, 8'h03, 0); add_vec(8'hA3, 1, 8'h03, 1);
    add_vec(8'h12, 0, 8'h00, 0); add_vec(8'h34, 0, 8'h00, 0);
    add_vec(8'h55, 0, 8'h00, 0); add_vec(8'h01, 0, 8'h00, 0); add_vec(8'h00, 0, 8'h00, 0);
    add_vec(8'h55, 0, 8'h00, 0); add_vec(8'h01, 0, 8'h00, 0);
    add_vec(8'h01, 0, 8'h00, 0); add_vec(8'h5A, 1, 8'h01, 1);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tready",   32'(tready),   32'd0);
    check("rst_rlen",     32'(rlen),     32'd0);
    check("rst_rdata",    32'(rdata),    32'd0);
    check("rst_rlast",    32'(rlast),    32'd0);
    check("rst_rvalid",   32'(rvalid),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_reset", 32'(tready), 32'd1);

    // Rx table, full-rate back-to-back bytes
    foreach (vecs[i]) begin
      @(negedge clk);
      rx_put(vecs[i].d, vecs[i].ev, vecs[i].el, vecs[i].elast);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rx_table_all_seen", 32'(rx_exp_q.size()), 32'd0);

    // Gap shorter than the timeout keeps the frame alive
    rx_send(8'h55, 0, 8'h00, 0); rx_send(8'h01, 0, 8'h00, 0);
    rx_send(8'h02, 0, 8'h00, 0); rx_send(8'h31, 1, 8'h02, 0);
    repeat (TMO / 2) @(negedge clk);
    rx_send(8'h32, 1, 8'h02, 1);

    // Timeout aborts a partial frame; rlen holds
    rx_send(8'h55, 0, 8'h00, 0); rx_send(8'h01, 0, 8'h00, 0);
    rx_send(8'h04, 0, 8'h00, 0); rx_send(8'h11, 1, 8'h04, 0);
    repeat (TMO + 20) @(negedge clk);
    check("rlen_held_after_timeout", 32'(rlen), 32'd4);
    rx_send(8'h55, 0, 8'h00, 0); rx_send(8'h01, 0, 8'h00, 0);
    rx_send(8'h01, 0, 8'h00, 0); rx_send(8'h22, 1, 8'h01, 1);
    repeat (3) @(negedge clk);
    check("rx_timeout_all_seen", 32'(rx_exp_q.size()), 32'd0);

    // DMA burst 55 01 01 77, with an rx frame arriving in the same cycles
    tx_seen = 1'b0;
    begin
      logic [7:0] burst [4];
      int unsigned c0;
      burst[0] = 8'h55; burst[1] = 8'h01; burst[2] = 8'h01; burst[3] = 8'h77;
      c0 = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i == 0) c0 = cyc;
        tdata  = burst[i];
        tlast  = (i == 3);
        tvalid = 1'b1;
        tx_exp_q.push_back(burst[i]);
        rx_put(burst[i], i == 3, 8'h01, i == 3);
      end
      @(negedge clk);
      tvalid = 1'b0; tlast = 1'b0; rx_valid = 1'b0;
      wait_tx_drained(200);
      check("tx_first_latency", tx_first_cyc - c0, 32'd3);
      check("rx_during_tx_seen", 32'(rx_exp_q.size()), 32'd0);
    end
    repeat (20) @(negedge clk);

    // Overflow: UART held busy, DEPTH+3 writes back-to-back
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < DEPTH + 3; i++) begin
      @(negedge clk);
      check("tready_during_fill", 32'(tready), 32'(i < DEPTH));
      tdata  = 8'(8'h80 + 8'(i));
      tvalid = 1'b1;
      if (i < DEPTH) tx_exp_q.push_back(8'(8'h80 + 8'(i)));
    end
    @(negedge clk);
    tvalid = 1'b0;
    check("tready_low_when_full", 32'(tready), 32'd0);
    repeat (10) @(negedge clk);
    check("tx_held_while_busy", 32'(tx_exp_q.size()), 32'(DEPTH));
    hold_busy = 1'b0;
    wait_tx_drained(DEPTH * 20);
    repeat (30) @(negedge clk);
    check("tready_after_drain", 32'(tready), 32'd1);

    // Reset mid-operation: partial rx frame and buffered tx bytes are dropped
    hold_busy = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tdata  = 8'(8'hC0 + 8'(i));
      tvalid = 1'b1;
      rx_put((i == 0) ? 8'h55 : ((i == 1) ? 8'h01 : 8'h02), 0, 8'h00, 0);
    end
    @(negedge clk);
    tvalid = 1'b0; rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("tready_in_mid_reset", 32'(tready), 32'd0);
    rst = 1'b0;
    hold_busy = 1'b0;
    rx_send(8'h33, 0, 8'h00, 0);
    rx_send(8'h55, 0, 8'h00, 0); rx_send(8'h01, 0, 8'h00, 0);
    rx_send(8'h01, 0, 8'h00, 0); rx_send(8'h44, 1, 8'h01, 1);
    repeat (40) @(negedge clk);
    check("rx_after_reset_seen", 32'(rx_exp_q.size()), 32'd0);
    check("tready_after_mid_reset", 32'(tready), 32'd1);
    check("rlen_after_mid_reset", 32'(rlen), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
